// File: rtl/arm_dec_pkg.sv
// Shared encodings and the packed control word for the ARM-subset decoder.
// The optional illegal-instruction output is enabled by ILLEGAL_DETECT_EN.
package arm_dec_pkg;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] IMM_8  = 2'b00;
   localparam logic [1:0] IMM_12 = 2'b01;
   localparam logic [1:0] IMM_24 = 2'b10;

   // LSB slot carries the illegal flag when detection is built in, else 0.
   typedef struct packed {
      logic [1:0] flagW;
      logic       pcs;
      logic       regW;
      logic       memW;
      logic       memToReg;
      logic       aluSrc;
      logic [1:0] immSrc;
      logic [1:0] regSrc;
      logic [1:0] aluControl;
      logic       branch;
      logic       illegal;
   } ctrl_t;

   function automatic logic cmd_supported(input logic [3:0] cmd);
      return (cmd == CMD_AND) || (cmd == CMD_SUB) ||
             (cmd == CMD_ADD) || (cmd == CMD_ORR);
   endfunction

endpackage

// File: rtl/arm_alu_decoder.sv
// Combinational ALU decoder: maps cmd/S to ALU control and flag-write enables.
// Unchanged by ILLEGAL_DETECT_EN.
module arm_alu_decoder
   import arm_dec_pkg::*;
(
   input  logic [5:0] funct,
   input  logic       aluOp,
   output logic [1:0] aluControl,
   output logic [1:0] flagW
);

   logic [3:0] cmd;
   logic       s_bit;
   logic       unused_imm;

   assign cmd        = funct[4:1];
   assign s_bit      = funct[0];
   assign unused_imm = funct[5];

   always_comb begin
      aluControl = ALU_ADD;
      flagW      = 2'b00;
      if (aluOp) begin
         case (cmd)
            CMD_ADD: aluControl = ALU_ADD;
            CMD_SUB: aluControl = ALU_SUB;
            CMD_AND: aluControl = ALU_AND;
            CMD_ORR: aluControl = ALU_ORR;
            default: aluControl = ALU_ADD;
         endcase
         // Carry/overflow are only meaningful for arithmetic operations.
         flagW[1] = s_bit;
         flagW[0] = s_bit && ((aluControl == ALU_ADD) || (aluControl == ALU_SUB));
      end
   end

endmodule

// File: rtl/arm_instr_decoder.sv
// Registered control decoder for a single-cycle ARM-subset datapath.
// Define ILLEGAL_DETECT_EN to add the registered 'illegal' output.
module arm_instr_decoder
   import arm_dec_pkg::*;
#(
   parameter logic [3:0] PC_REG = 4'd15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
`ifdef ILLEGAL_DETECT_EN
   output logic       illegal,
`endif
   output logic [1:0] flagW,
   output logic       pcs,
   output logic       regW,
   output logic       memW,
   output logic       memToReg,
   output logic       aluSrc,
   output logic [1:0] immSrc,
   output logic [1:0] regSrc,
   output logic [1:0] aluControl,
   output logic       branch
);

   logic       dec_branch;
   logic       dec_memToReg;
   logic       dec_memW;
   logic       dec_aluSrc;
   logic [1:0] dec_immSrc;
   logic       dec_regW;
   logic [1:0] dec_regSrc;
   logic       dec_aluOp;
   logic [1:0] dec_aluControl;
   logic [1:0] dec_flagW;
   logic       dec_illegal;

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   // Main decoder; unused combinations and don't-cares stay 0.
   always_comb begin
      dec_branch   = 1'b0;
      dec_memToReg = 1'b0;
      dec_memW     = 1'b0;
      dec_aluSrc   = 1'b0;
      dec_immSrc   = IMM_8;
      dec_regW     = 1'b0;
      dec_regSrc   = 2'b00;
      dec_aluOp    = 1'b0;
      case (op)
         OP_DP: begin
            dec_aluSrc = funct[5];
            dec_regW   = 1'b1;
            dec_aluOp  = 1'b1;
         end
         OP_MEM: begin
            dec_aluSrc = 1'b1;
            dec_immSrc = IMM_12;
            if (funct[0]) begin
               dec_memToReg = 1'b1;
               dec_regW     = 1'b1;
            end else begin
               dec_memW   = 1'b1;
               dec_regSrc = 2'b10;
            end
         end
         OP_BR: begin
            dec_branch = 1'b1;
            dec_aluSrc = 1'b1;
            dec_immSrc = IMM_24;
            dec_regSrc = 2'b01;
         end
         default: ;
      endcase
   end

   arm_alu_decoder u_alu_dec (
      .funct      (funct),
      .aluOp      (dec_aluOp),
      .aluControl (dec_aluControl),
      .flagW      (dec_flagW)
   );

`ifdef ILLEGAL_DETECT_EN
   assign dec_illegal = (op == 2'b11) || ((op == OP_DP) && !cmd_supported(funct[4:1]));
`else
   assign dec_illegal = 1'b0;
`endif

   always_comb begin
      ctrl_d            = '0;
      ctrl_d.flagW      = dec_flagW;
      ctrl_d.pcs        = ((rd == PC_REG) && dec_regW) || dec_branch;
      ctrl_d.regW       = dec_regW;
      ctrl_d.memW       = dec_memW;
      ctrl_d.memToReg   = dec_memToReg;
      ctrl_d.aluSrc     = dec_aluSrc;
      ctrl_d.immSrc     = dec_immSrc;
      ctrl_d.regSrc     = dec_regSrc;
      ctrl_d.aluControl = dec_aluControl;
      ctrl_d.branch     = dec_branch;
      ctrl_d.illegal    = dec_illegal;
   end

   // Single register for the whole word keeps all outputs updating together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign flagW      = ctrl_q.flagW;
   assign pcs        = ctrl_q.pcs;
   assign regW       = ctrl_q.regW;
   assign memW       = ctrl_q.memW;
   assign memToReg   = ctrl_q.memToReg;
   assign aluSrc     = ctrl_q.aluSrc;
   assign immSrc     = ctrl_q.immSrc;
   assign regSrc     = ctrl_q.regSrc;
   assign aluControl = ctrl_q.aluControl;
   assign branch     = ctrl_q.branch;

`ifdef ILLEGAL_DETECT_EN
   assign illegal = ctrl_q.illegal;
`else
   logic unused_illegal;
   assign unused_illegal = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_arm_instr_decoder.sv
// Bench for arm_instr_decoder: table-driven model, per-cycle scoreboard, directed vectors.
// Honours ILLEGAL_DETECT_EN when the design is built with it.
module tb_arm_instr_decoder;

   logic       clk;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [1:0] flagW;
   logic       pcs;
   logic       regW;
   logic       memW;
   logic       memToReg;
   logic       aluSrc;
   logic [1:0] immSrc;
   logic [1:0] regSrc;
   logic [1:0] aluControl;
   logic       branch;
   logic       ill_bit;

   int total = 0;
   int bad   = 0;
   logic [14:0] exp_q[$];
   logic [14:0] dut_vec;

`ifdef ILLEGAL_DETECT_EN
   localparam logic ILL_EN = 1'b1;
   logic illegal;
   assign ill_bit = illegal;
`else
   localparam logic ILL_EN = 1'b0;
   assign ill_bit = 1'b0;
`endif

   arm_instr_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .rd         (rd),
`ifdef ILLEGAL_DETECT_EN
      .illegal    (illegal),
`endif
      .flagW      (flagW),
      .pcs        (pcs),
      .regW       (regW),
      .memW       (memW),
      .memToReg   (memToReg),
      .aluSrc     (aluSrc),
      .immSrc     (immSrc),
      .regSrc     (regSrc),
      .aluControl (aluControl),
      .branch     (branch)
   );

   assign dut_vec = {flagW, pcs, regW, memW, memToReg, aluSrc, immSrc, regSrc,
                     aluControl, branch, ill_bit};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   // Reference model: classify the instruction, look up its main-decoder row.
   function automatic logic [14:0] model(input logic [1:0] o, input logic [5:0] f,
                                         input logic [3:0] r);
      logic [9:0] row;  // branch memToReg memW aluSrc immSrc[2] regW regSrc[2] aluOp
      logic [1:0] ctl;
      logic [1:0] fw;
      logic [3:0] cmd;
      logic       p;
      logic       ill;
      int         cls;
      cmd = f[4:1];
      case (o)
         2'b00:   cls = f[5] ? 1 : 0;
         2'b01:   cls = f[0] ? 3 : 2;
         2'b10:   cls = 4;
         default: cls = 5;
      endcase
      case (cls)
         0:       row = 10'b0_0_0_0_00_1_00_1;
         1:       row = 10'b0_0_0_1_00_1_00_1;
         2:       row = 10'b0_0_1_1_01_0_10_0;
         3:       row = 10'b0_1_0_1_01_1_00_0;
         4:       row = 10'b1_0_0_1_10_0_01_0;
         default: row = 10'b0;
      endcase
      ctl = 2'b00;
      fw  = 2'b00;
      if (row[0]) begin
         if      (cmd == 4'b0100) ctl = 2'd0;
         else if (cmd == 4'b0010) ctl = 2'd1;
         else if (cmd == 4'b0000) ctl = 2'd2;
         else if (cmd == 4'b1100) ctl = 2'd3;
         fw[1] = f[0];
         fw[0] = f[0] && (ctl < 2'd2);
      end
      p   = ((r == 4'd15) && row[3]) || row[9];
      ill = (o == 2'b11) ||
            ((o == 2'b00) && !(cmd == 4'b0000 || cmd == 4'b0010 ||
                               cmd == 4'b0100 || cmd == 4'b1100));
      return {fw, p, row[3], row[7], row[8], row[6], row[5:4], row[2:1], ctl, row[9],
              ILL_EN & ill};
   endfunction

   // scoreboard: expectation formed from inputs at each edge, checked 1 ns later
   always @(posedge clk) begin
      exp_q.push_back(reset ? model(op, funct, rd) : 15'd0);
      #1;
      check("cycle", dut_vec, exp_q.pop_front());
   end

   function automatic logic [31:0] mk(input logic [1:0] o, input logic [5:0] f,
                                      input logic [3:0] r);
      return {4'hE, o, f, 4'h0, r, 12'h000};
   endfunction

   // driver: inputs change on negedge, literal result checked after the next posedge
   task automatic apply(input logic [31:0] instr, input logic [14:0] lit,
                        input string name, input logic has_lit);
      op    = instr[27:26];
      funct = instr[25:20];
      rd    = instr[15:12];
      @(posedge clk);
      #2;
      if (has_lit) check(name, dut_vec, lit);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      op    = 2'b00;
      funct = 6'b001000;
      rd    = 4'd1;
      #3;
      check("reset_state", dut_vec, 15'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      apply(32'hE0821003, 15'b000100000000000, "add_reg", 1'b1);
      apply(32'hE2510005, 15'b110100100000100, "subs_imm", 1'b1);
      apply(32'hE5902004, 15'b000101101000000, "ldr", 1'b1);
      apply(32'hE5801008, 15'b000010101100000, "str", 1'b1);
      apply(32'hEA000002, 15'b001000110010010, "b", 1'b1);
      apply(32'hE082F003, 15'b001100000000000, "add_pc", 1'b1);
      apply(mk(2'b00, 6'b011001, 4'd3),  15'b100100000001100, "orrs_reg", 1'b1);
      apply(mk(2'b00, 6'b100001, 4'd3),  15'b100100100001000, "ands_imm", 1'b1);
      apply(mk(2'b00, 6'b000011, 4'd3),  {14'b11010000000000, ILL_EN}, "eors_other", 1'b1);
      apply(mk(2'b11, 6'b101011, 4'd15), {14'd0, ILL_EN}, "op11", 1'b1);
      apply(mk(2'b01, 6'b011001, 4'd15), 15'b001101101000000, "ldr_pc", 1'b1);
      apply(mk(2'b01, 6'b011000, 4'd15), 15'b000010101100000, "str_pc", 1'b1);

      // sweep every op/funct with rd either a plain register or the PC
      for (int o = 0; o < 4; o++) begin
         for (int f = 0; f < 64; f++) begin
            apply(mk(o[1:0], f[5:0], 4'd4), 15'd0, "sweep", 1'b0);
            apply(mk(o[1:0], f[5:0], 4'd15), 15'd0, "sweep", 1'b0);
         end
      end

      // asynchronous reset mid-stream
      op    = 2'b10;
      funct = 6'b000000;
      rd    = 4'd0;
      @(posedge clk);
      #2;
      check("b_pre_reset", dut_vec, 15'b001000110010010);
      reset = 1'b0;
      #1;
      check("async_clear", dut_vec, 15'd0);
      @(negedge clk);
      check("reset_hold", dut_vec, 15'd0);
      reset = 1'b1;
      apply(32'hE2510005, 15'b110100100000100, "after_release", 1'b1);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
